// File: rtl/decstage_pipe.sv
// decstage_pipe: decode stage with register file, immediate extension and a
// single-entry valid/ready output register.
//
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   Instr, In_valid     incoming instruction (rs [25:21], rd [20:16],
//   In_ready            rt [15:11], imm [15:0]) and its handshake
//   RF_B_sel            read port B address: 0 = rt, 1 = rd
//   Imm_mode            00 sext, 01 zext, 10 imm<<16, 11 sext<<2
//   RF_WrEn, WB_Addr,   write-back port; data is MEM_out when
//   RF_WrData_sel,      RF_WrData_sel = 1, ALU_out otherwise
//   ALU_out, MEM_out
//   Out_valid, Out_ready  output handshake
//   RF_A, RF_B, Immed, Rd_out  registered decode results
//
// Configuration:
//   DECSTAGE_BYPASS_EN  when defined, a write-back on the same edge as an
//                       accept forwards its data into RF_A/RF_B. Otherwise
//                       the captured operands are the pre-write contents.

module decstage_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_CNT = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [31:0]       Instr,
   input  logic              In_valid,
   output logic              In_ready,
   input  logic              RF_B_sel,
   input  logic [1:0]        Imm_mode,
   input  logic              RF_WrEn,
   input  logic [4:0]        WB_Addr,
   input  logic              RF_WrData_sel,
   input  logic [DATA_W-1:0] ALU_out,
   input  logic [DATA_W-1:0] MEM_out,
   output logic              Out_valid,
   input  logic              Out_ready,
   output logic [DATA_W-1:0] RF_A,
   output logic [DATA_W-1:0] RF_B,
   output logic [DATA_W-1:0] Immed,
   output logic [4:0]        Rd_out
);

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned IMM_W  = 16;

   // Instruction fields
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] rt;
   logic [IMM_W-1:0]  imm;
   logic [ADDR_W-1:0] addr_b;
   logic              unused_opcode;

   assign rs            = Instr[25:21];
   assign rd            = Instr[20:16];
   assign rt            = Instr[15:11];
   assign imm           = Instr[15:0];
   assign addr_b        = RF_B_sel ? rd : rt;
   assign unused_opcode = ^Instr[31:26];

   // Storage only for r1..r(REG_CNT-1); r0 and out-of-range addresses have none
   logic [DATA_W-1:0] regs [1:REG_CNT-1];
   logic [DATA_W-1:0] wr_data;

   assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int unsigned i = 1; i < REG_CNT; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < REG_CNT; i++) begin
            if (RF_WrEn && (WB_Addr == ADDR_W'(i))) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // Read ports; unmatched addresses (r0, out of range) fall through to zero
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int unsigned i = 1; i < REG_CNT; i++) begin
         if (rs == ADDR_W'(i)) begin
            rd_a = regs[i];
`ifdef DECSTAGE_BYPASS_EN
            if (RF_WrEn && (WB_Addr == rs)) begin
               rd_a = wr_data;
            end
`endif
         end
         if (addr_b == ADDR_W'(i)) begin
            rd_b = regs[i];
`ifdef DECSTAGE_BYPASS_EN
            if (RF_WrEn && (WB_Addr == addr_b)) begin
               rd_b = wr_data;
            end
`endif
         end
      end
   end

   // Immediate extension
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_ext;

   assign imm_sext = DATA_W'($signed(imm));

   always_comb begin
      imm_ext = imm_sext;
      unique case (Imm_mode)
         2'b00: imm_ext = imm_sext;
         2'b01: imm_ext = DATA_W'(imm);
         2'b10: imm_ext = DATA_W'({imm, 16'h0000});
         2'b11: imm_ext = imm_sext << 2;
         default: imm_ext = imm_sext;
      endcase
   end

   // Single-entry output register
   logic accept;

   assign In_ready = !Out_valid || Out_ready;
   assign accept   = In_valid && In_ready;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Out_valid <= 1'b0;
         RF_A      <= '0;
         RF_B      <= '0;
         Immed     <= '0;
         Rd_out    <= '0;
      end else if (accept) begin
         Out_valid <= 1'b1;
         RF_A      <= rd_a;
         RF_B      <= rd_b;
         Immed     <= imm_ext;
         Rd_out    <= rd;
      end else if (Out_ready) begin
         Out_valid <= 1'b0;
      end
   end

endmodule
